accel_bcd_display: RTL and testbench
====================================

# accel_bcd_display

Parametrised, multi-channel signed-sample to BCD display formatter for the accelerometer path. It sits between the SPI controller's axis outputs and the 7-segment decoders, and replaces per-axis combinational divide/modulo with one shared serial double-dabble converter. It captures samples on the data-update strobe and converts all channels on a periodic refresh tick. The displayed digit, sign and overflow state is committed atomically so the display never shows a mix of old and new channels.

## Interface
- DATA_W, 16, sample width (signed two's complement)
- NUM_CH, 3, channel count (0=z, 1=x, 2=y by convention)
- DIGITS, 2, BCD digits shown per channel
- REFRESH_DIV, 25_000_000, clk cycles per refresh tick; must be >= NUM_CH*(DATA_W+2)+2

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  NUM_CH*DATA_W  packed samples, channel c at [c*DATA_W +: DATA_W]
- data_valid  in  1  one-cycle strobe; captures data_in into the sample register
- hold  in  1  freeze display; refresh ticks ignored while high
- bcd_out  out  NUM_CH*DIGITS*4  channel c digit d (d=0 units) at [(c*DIGITS+d)*4 +: 4]
- sign_out  out  NUM_CH  1 = committed sample negative
- ovf_out  out  NUM_CH  1 = |sample| >= 10^DIGITS, digits saturated to 9
- busy  out  1  conversion in progress (FSM not IDLE)
- update_done  out  1  one-cycle pulse when outputs commit

## Operation
- Sample register: loaded from data_in on every data_valid; reset value 0.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps; tick = counter at REFRESH_DIV-1. It runs freely regardless of FSM state or hold.
- Snapshot on accepted tick: source = data_in if data_valid is high in the same cycle, else the sample register.
- A tick is accepted only when the FSM is IDLE and hold=0. Otherwise it is dropped, not queued.
- FSM states:
  - IDLE: accepted tick -> LOAD with ch=0.
  - LOAD: compute sign = msb, abs = two's-complement magnitude as an unsigned DATA_W value (-2^(DATA_W-1) maps to 2^(DATA_W-1), no wrap), ovf = abs >= 10^DIGITS. Clear the BCD shift register -> SHIFT.
  - SHIFT: exactly DATA_W cycles, MSB first. Each cycle: add 3 to every BCD digit >= 5, then shift left one bit with the next abs bit in -> STORE.
  - STORE: write digits (all 9s if ovf), sign and ovf into the channel-ch shadow. If ch==NUM_CH-1 -> DONE, else ch+1 -> LOAD.
  - DONE: copy all shadow registers into bcd_out/sign_out/ovf_out in one edge, pulse update_done -> IDLE.
- Zero displays as all-zero digits, sign 0, ovf 0.
- data_valid during conversion updates only the sample register. The in-flight conversion uses the snapshot, and the new value appears at the next accepted tick.
- hold=1 leaves outputs unchanged. A conversion already in flight completes and commits.

## Timing
- Reset values: bcd_out=0, sign_out=0, ovf_out=0, busy=0, update_done=0, sample register=0, refresh counter=0, FSM=IDLE.
- Reset asserted mid-conversion aborts it with no commit. All of the above return to reset values on the next edge.
- Tick in cycle T: busy=1 from T+1 through T+NUM_CH*(DATA_W+2)+1.
- New outputs and update_done=1 appear together at T+NUM_CH*(DATA_W+2)+2. busy=0 in that same cycle. Default parameters give T+56.
- update_done is exactly one cycle wide. Outputs are otherwise stable between commits.
- Per channel: 1 LOAD + DATA_W SHIFT + 1 STORE cycle.

## Test plan
- Reset release, REFRESH_DIV=100: all outputs 0 and busy=0 until the first tick at counter=99. That commit shows 00/00/00 with signs 0.
- data_valid with z=-47, x=5, y=0, then tick at T: at T+56 ch0=4,7 sign1; ch1=0,5 sign0; ch2=0,0 sign0; ovf all 0; update_done one cycle; busy high T+1..T+55.
- Boundary values 99, 100, -32768, 32767: 99 -> 9,9 ovf0; 100 -> 9,9 ovf1; -32768 -> 9,9 sign1 ovf1; 32767 -> 9,9 ovf1.
- hold=1 across two ticks with changed data: outputs unchanged and no update_done. Release hold: the next tick commits the latest sample.
- data_valid coincident with tick: the new value is converted. data_valid mid-SHIFT: the committed value is the old snapshot, and the new value is shown after the following tick.
- reset pulsed during SHIFT of ch1: no update_done, outputs 0, busy 0. The next tick occurs REFRESH_DIV cycles after reset release.

Source files
------------

// File: rtl/accel_bcd_display_if.sv
// Bus between the accelerometer sample source and the BCD display formatter.
// The master side supplies samples and hold; the slave side returns display state.
interface accel_bcd_display_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DIGITS = 2
);
  logic [NUM_CH*DATA_W-1:0]   data_in;
  logic                       data_valid;
  logic                       hold;
  logic [NUM_CH*DIGITS*4-1:0] bcd_out;
  logic [NUM_CH-1:0]          sign_out;
  logic [NUM_CH-1:0]          ovf_out;
  logic                       busy;
  logic                       update_done;

  modport master (
    output data_in, data_valid, hold,
    input  bcd_out, sign_out, ovf_out, busy, update_done
  );

  modport slave (
    input  data_in, data_valid, hold,
    output bcd_out, sign_out, ovf_out, busy, update_done
  );
endinterface

// File: rtl/accel_bcd_display.sv
// Multi-channel signed sample to BCD formatter: one shared serial double-dabble
// converter, run per refresh tick, with an atomic commit of all channels.
module accel_bcd_display #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned REFRESH_DIV = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  accel_bcd_display_if.slave bus
);
  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           ref_cnt;
  logic                       tick, accept;
  logic [NUM_CH*DATA_W-1:0]   sample, snap;
  logic [CH_W-1:0]            ch;
  logic [BIT_W-1:0]           bit_cnt;
  logic [DATA_W-1:0]          chan, chan_abs, abs_sr;
  logic                       chan_ovf, cur_sign, cur_ovf;
  logic [BCD_W-1:0]           bcd_sr, bcd_adj, bcd_nxt;
  logic [NUM_CH*BCD_W-1:0]    bcd_sh, bcd_q;
  logic [NUM_CH-1:0]          sign_sh, ovf_sh, sign_q, ovf_q;
  logic                       done_q;

  assign tick   = (ref_cnt == CNT_W'(REFRESH_DIV - 1));
  assign accept = (state == S_IDLE) && tick && !bus.hold;

  // Magnitude kept unsigned so the most negative sample does not wrap.
  assign chan     = snap[ch*DATA_W +: DATA_W];
  assign chan_abs = chan[DATA_W-1] ? (~chan + DATA_W'(1)) : chan;
  assign chan_ovf = (64'(chan_abs) >= LIMIT);

  always_comb begin
    bcd_adj = bcd_sr;
    for (int unsigned d = 0; d < DIGITS; d++)
      if (bcd_sr[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_sr[d*4 +: 4] + 4'd3;
    bcd_nxt = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, abs_sr[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (bit_cnt == BIT_W'(DATA_W - 1)) state_nxt = S_STORE;
      S_STORE: state_nxt = (ch == CH_W'(NUM_CH - 1)) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt  <= '0;
      sample   <= '0;
      snap     <= '0;
      ch       <= '0;
      bit_cnt  <= '0;
      abs_sr   <= '0;
      bcd_sr   <= '0;
      cur_sign <= 1'b0;
      cur_ovf  <= 1'b0;
      bcd_sh   <= '0;
      sign_sh  <= '0;
      ovf_sh   <= '0;
      bcd_q    <= '0;
      sign_q   <= '0;
      ovf_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + CNT_W'(1);
      if (bus.data_valid) sample <= bus.data_in;
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          snap <= bus.data_valid ? bus.data_in : sample;
          ch   <= '0;
        end
        S_LOAD: begin
          abs_sr   <= chan_abs;
          cur_sign <= chan[DATA_W-1];
          cur_ovf  <= chan_ovf;
          bcd_sr   <= '0;
          bit_cnt  <= '0;
        end
        S_SHIFT: begin
          bcd_sr  <= bcd_nxt;
          abs_sr  <= abs_sr << 1;
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
        S_STORE: begin
          bcd_sh[ch*BCD_W +: BCD_W] <= cur_ovf ? {DIGITS{4'd9}} : bcd_sr;
          sign_sh[ch] <= cur_sign;
          ovf_sh[ch]  <= cur_ovf;
          if (ch != CH_W'(NUM_CH - 1)) ch <= ch + CH_W'(1);
        end
        S_DONE: begin
          bcd_q  <= bcd_sh;
          sign_q <= sign_sh;
          ovf_q  <= ovf_sh;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.sign_out    = sign_q;
  assign bus.ovf_out     = ovf_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.update_done = done_q;
endmodule

// File: tb/tb_accel_bcd_display.sv
// Directed plus randomized bench for accel_bcd_display against an arithmetic
// reference model of the displayed digits, sign and overflow.
module tb_accel_bcd_display;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned DIGITS      = 2;
  localparam int unsigned REFRESH_DIV = 100;
  localparam int unsigned CONV        = NUM_CH * (DATA_W + 2) + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  accel_bcd_display_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus ();

  accel_bcd_display #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int ph = 0;
  logic [47:0] sample_m;
  logic [23:0] disp_bcd;
  logic [2:0]  disp_sign, disp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    ph = r ? 0 : (ph + 1) % REFRESH_DIV;
  endtask

  function automatic void model(input logic [47:0] d, output logic [23:0] b,
                                output logic [2:0] s, output logic [2:0] o);
    int v, a;
    b = '0; s = '0; o = '0;
    for (int c = 0; c < 3; c++) begin
      v = int'($signed(d[c*16 +: 16]));
      a = (v < 0) ? -v : v;
      s[c] = (v < 0);
      o[c] = (a >= 100);
      b[c*8 +: 4]     = o[c] ? 4'd9 : 4'(a % 10);
      b[c*8 + 4 +: 4] = o[c] ? 4'd9 : 4'(a / 10);
    end
  endfunction

  function automatic logic [15:0] rand_sample();
    if ($urandom_range(0, 2) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 240)) - 120);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_done"}, 64'(bus.update_done), 64'(0));
    chk({tag, "_bcd"}, 64'(bus.bcd_out), 64'(disp_bcd));
    chk({tag, "_sign"}, 64'(bus.sign_out), 64'(disp_sign));
    chk({tag, "_ovf"}, 64'(bus.ovf_out), 64'(disp_ovf));
  endtask

  task automatic pulse_valid(input logic [47:0] d);
    bus.data_in = d;
    bus.data_valid = 1'b1;
    sample_m = d;
    step();
    bus.data_valid = 1'b0;
  endtask

  // Leaves the bench inside the cycle in which the refresh counter is at its top.
  task automatic goto_tick(input string tag);
    while (ph != REFRESH_DIV - 1) begin
      check_idle(tag);
      step();
    end
  endtask

  task automatic conv_check(input string tag, input logic [47:0] d,
                            input int inj_k, input logic [47:0] inj_d);
    logic [23:0] eb;
    logic [2:0] es, eo;
    model(d, eb, es, eo);
    for (int k = 1; k <= int'(CONV) + 1; k++) begin
      step();
      bus.data_valid = 1'b0;
      if (k == inj_k) begin
        bus.data_in = inj_d;
        bus.data_valid = 1'b1;
        sample_m = inj_d;
      end
      if (k < int'(CONV)) begin
        chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
        chk({tag, "_nodone"}, 64'(bus.update_done), 64'(0));
        chk({tag, "_stable"}, 64'(bus.bcd_out), 64'(disp_bcd));
      end else if (k == int'(CONV)) begin
        chk({tag, "_done"}, 64'(bus.update_done), 64'(1));
        chk({tag, "_idle"}, 64'(bus.busy), 64'(0));
        chk({tag, "_bcd"}, 64'(bus.bcd_out), 64'(eb));
        chk({tag, "_sign"}, 64'(bus.sign_out), 64'(es));
        chk({tag, "_ovf"}, 64'(bus.ovf_out), 64'(eo));
        disp_bcd = eb; disp_sign = es; disp_ovf = eo;
      end else begin
        chk({tag, "_pulse1"}, 64'(bus.update_done), 64'(0));
        chk({tag, "_hold"}, 64'(bus.bcd_out), 64'(disp_bcd));
      end
    end
  endtask

  initial begin
    logic [47:0] d;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    bus.hold = 1'b0;
    sample_m = '0;
    disp_bcd = '0; disp_sign = '0; disp_ovf = '0;

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_idle("reset");

    goto_tick("first");
    conv_check("first", sample_m, 0, '0);

    pulse_valid({16'd0, 16'd5, 16'hFFD1});
    goto_tick("mixed");
    conv_check("mixed", sample_m, 0, '0);

    pulse_valid({16'h8000, 16'd100, 16'd99});
    goto_tick("bound_a");
    conv_check("bound_a", sample_m, 0, '0);
    pulse_valid({16'hFF9C, 16'hFF9D, 16'd32767});
    goto_tick("bound_b");
    conv_check("bound_b", sample_m, 0, '0);

    bus.hold = 1'b1;
    pulse_valid({16'd3, 16'hFFFE, 16'd1});
    for (int i = 0; i < 2 * int'(REFRESH_DIV) + 10; i++) begin
      check_idle("hold");
      step();
    end
    bus.hold = 1'b0;
    goto_tick("unhold");
    conv_check("unhold", sample_m, 0, '0);

    goto_tick("coinc");
    d = {16'd42, 16'hFFF9, 16'd88};
    bus.data_in = d;
    bus.data_valid = 1'b1;
    sample_m = d;
    conv_check("coinc", d, 0, '0);

    d = sample_m;
    goto_tick("midshift");
    conv_check("midshift", d, 10, {16'd11, 16'd22, 16'hFFDF});
    goto_tick("after_mid");
    conv_check("after_mid", sample_m, 0, '0);

    pulse_valid({16'd77, 16'd66, 16'd55});
    goto_tick("abort");
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("abort_busy", 64'(bus.busy), 64'(1));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    disp_bcd = '0; disp_sign = '0; disp_ovf = '0;
    sample_m = '0;
    check_idle("abort_rst");
    goto_tick("abort_wait");
    conv_check("abort_next", sample_m, 0, '0);

    for (int it = 0; it < 20; it++) begin
      int inj;
      d = {rand_sample(), rand_sample(), rand_sample()};
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, CONV - 1)) : 0;
      if ($urandom_range(0, 1) == 0) begin
        pulse_valid(d);
        goto_tick("rnd");
      end else begin
        goto_tick("rnd");
        bus.data_in = d;
        bus.data_valid = 1'b1;
        sample_m = d;
      end
      conv_check("rnd", d, inj, {rand_sample(), rand_sample(), rand_sample()});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
